// File: rtl/fp16_add_arbiter.sv
// Round-robin sequencer sharing one fp16 adder among NREQ lanes; issues one
// operand pair at a time, returns the tagged sum, and times out a silent adder.
//   state   | meaning
//   S_IDLE  | arbitrate; grant latches operands and raises add_valid
//   S_ISSUE | add_valid high for this single cycle
//   S_WAIT  | wait for add_complete or watchdog expiry
module fp16_add_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*16-1:0]   req_data1,
    input  logic [NREQ*16-1:0]   req_data2,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [15:0]          rsp_result,
    output logic                 rsp_err,
    output logic                 busy,
    output logic [15:0]          add_data1,
    output logic [15:0]          add_data2,
    output logic                 add_valid,
    input  logic [15:0]          add_result,
    input  logic                 add_complete
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]     state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [15:0]    a_q, a_d, b_q, b_d;
    logic           av_q, av_d;
    logic           rv_q, rv_d;
    logic [IDW-1:0] rid_q, rid_d;
    logic [15:0]    rres_q, rres_d;
    logic           rerr_q, rerr_d;

    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   req_rot;
    logic              grant_any;
    logic [IDW-1:0]    grant_id;
    logic [IDW-1:0]    grant_nxt;
    int                sel;
    int                nxt;

    // Rotate requests so bit 0 is the lane at ptr; the lowest set bit wins.
    always_comb begin
        req_dbl   = {req_valid, req_valid} >> ptr_q;
        req_rot   = req_dbl[NREQ-1:0];
        grant_any = 1'b0;
        sel       = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                grant_any = 1'b1;
                sel       = int'(ptr_q) + k;
            end
        end
        if (sel >= NREQ) sel = sel - NREQ;
        grant_id = IDW'(sel);
        nxt      = sel + 1;
        if (nxt >= NREQ) nxt = 0;
        grant_nxt = IDW'(nxt);
    end

    assign req_ready = (state_q == S_IDLE && grant_any && !rst) ?
                       (NREQ'(1) << grant_id) : '0;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        av_d    = 1'b0;
        rv_d    = 1'b0;
        rid_d   = rid_q;
        rres_d  = rres_q;
        rerr_d  = rerr_q;
        case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    a_d     = req_data1[16*grant_id +: 16];
                    b_d     = req_data2[16*grant_id +: 16];
                    id_d    = grant_id;
                    ptr_d   = grant_nxt;
                    av_d    = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = 8'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (add_complete) begin
                    rres_d  = add_result;
                    rid_d   = id_q;
                    rerr_d  = 1'b0;
                    rv_d    = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    rres_d  = 16'h0000;
                    rid_d   = id_q;
                    rerr_d  = 1'b1;
                    rv_d    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            cnt_q   <= 8'd0;
            a_q     <= 16'h0000;
            b_q     <= 16'h0000;
            av_q    <= 1'b0;
            rv_q    <= 1'b0;
            rid_q   <= '0;
            rres_q  <= 16'h0000;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            av_q    <= av_d;
            rv_q    <= rv_d;
            rid_q   <= rid_d;
            rres_q  <= rres_d;
            rerr_q  <= rerr_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign add_data1  = a_q;
    assign add_data2  = b_q;
    assign add_valid  = av_q;
    assign rsp_valid  = rv_q;
    assign rsp_id     = rid_q;
    assign rsp_result = rres_q;
    assign rsp_err    = rerr_q;

endmodule
